// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch sequencer for a 64-bit RISC-V front end.
// Drives inst_address from the PC register, captures the combinational
// instruction word one edge later and hands it to IF/ID with a valid flag.
//
// Parameters:
//   PROG_BYTES        size of the loaded image in bytes (last word at PROG_BYTES-4)
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   stall             IF/ID cannot accept; hold the current fetch
//   redirect          taken branch/jump; load redirect_target into PC
//   redirect_target   byte address of the next instruction
//   inst_address      address to instruction memory (copy of PC)
//   instruction       word returned by instruction memory
//   fetch_valid       fetch_pc / fetch_instruction hold a real instruction
//   fetch_pc          address of the delivered instruction
//   fetch_instruction delivered instruction word
//   fetch_count       saturating count of delivered instructions
//   halted            stopped at the end of the program image
//
// Build option: define FETCH_BOUNDS_CHECK_EN to enable end-of-image detection
// (HALT state). Without it the PC simply wraps modulo 2^64 and halted is 0.

module fetch_sequencer #(
    parameter int PROG_BYTES = 88
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    output logic [63:0] inst_address,
    input  logic [31:0] instruction,
    output logic        fetch_valid,
    output logic [63:0] fetch_pc,
    output logic [31:0] fetch_instruction,
    output logic [31:0] fetch_count,
    output logic        halted
);

    if (PROG_BYTES < 4 || (PROG_BYTES % 4) != 0) begin : g_bad_size
        $error("fetch_sequencer: PROG_BYTES must be a positive multiple of 4");
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [63:0] PROG_END = 64'(PROG_BYTES);
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [63:0] fpc_q, fpc_d;
    logic [31:0] finst_q, finst_d;
    logic [31:0] count_q, count_d;
`ifdef FETCH_BOUNDS_CHECK_EN
    logic        halted_q, halted_d;
`endif

    // Redirect targets are forced onto a word boundary.
    logic [63:0] target_aligned;
    assign target_aligned = redirect_target & ~64'h3;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        fpc_d    = fpc_q;
        finst_d  = finst_q;
        count_d  = count_q;
`ifdef FETCH_BOUNDS_CHECK_EN
        halted_d = halted_q;
`endif
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
                valid_d = 1'b0;
                if (redirect) begin
                    pc_d = target_aligned;
                end
            end
            RUN: begin
                if (redirect) begin
                    // Redirect wins over stall and inserts one bubble.
                    pc_d    = target_aligned;
                    valid_d = 1'b0;
                end
`ifdef FETCH_BOUNDS_CHECK_EN
                else if (pc_q >= PROG_END) begin
                    state_d  = HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end
`endif
                else if (!stall) begin
                    valid_d = 1'b1;
                    fpc_d   = pc_q;
                    finst_d = instruction;
                    pc_d    = pc_q + 64'd4;
                    if (count_q != 32'hFFFF_FFFF) begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
`ifdef FETCH_BOUNDS_CHECK_EN
            HALT: begin
                valid_d = 1'b0;
                // Only a redirect back into the image restarts fetching.
                if (redirect && (target_aligned < PROG_END)) begin
                    pc_d     = target_aligned;
                    halted_d = 1'b0;
                    state_d  = RUN;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= 64'd0;
            valid_q  <= 1'b0;
            fpc_q    <= 64'd0;
            finst_q  <= 32'd0;
            count_q  <= 32'd0;
`ifdef FETCH_BOUNDS_CHECK_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            fpc_q    <= fpc_d;
            finst_q  <= finst_d;
            count_q  <= count_d;
`ifdef FETCH_BOUNDS_CHECK_EN
            halted_q <= halted_d;
`endif
        end
    end

    assign inst_address      = pc_q;
    assign fetch_valid       = valid_q;
    assign fetch_pc          = fpc_q;
    assign fetch_instruction = finst_q;
    assign fetch_count       = count_q;
`ifdef FETCH_BOUNDS_CHECK_EN
    assign halted            = halted_q;
`else
    assign halted            = 1'b0;
`endif

endmodule
